imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//   Writer side of the instruction memory. The core only reads that memory (its write enable is tied low).
//   This block fills it from the io pads at power-up. A host sends a 16-bit word count, N little-endian
//   32-bit words and an XOR checksum, one byte per strobe.
//   The block holds the core in reset until the image is written and verified. It sits beside the core
//   in the user project, and drives the write port of the instruction RAM.
// PARAMETERS
//   ADDR_W       10  word-address width of instruction RAM (capacity 2**ADDR_W words)
//   SYNC_STAGES  2   flops in byte_stb synchronizer (>=2)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        synchronous, active-high reset
//   boot_req     in   1        host load request, level; pad-synchronous to clk by board design
//   byte_stb     in   1        async byte strobe from pad; each rising edge delivers one byte
//   byte_data    in   8        byte value; stable from before the strobe rise until SYNC_STAGES+2 clk after it
//   core_rst     out  1        reset to core; high while loading, on error and during rst
//   ram_we       out  1        one-cycle write pulse to instruction RAM
//   ram_addr     out  ADDR_W   word address of the write
//   ram_wdata    out  32       assembled word
//   busy         out  1        session in progress (LEN_LO..CHK)
//   done         out  1        last session passed checksum
//   err          out  1        last session failed
//   words_wr     out  ADDR_W+1 words written in current/last session
// BEHAVIOUR
//   Reset state: IDLE. core_rst=1 during rst. All other outputs are 0. All outputs are registered.
//   States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
//   Byte event: a rising edge of the synchronized byte_stb, detected once per edge.
//     - byte_data is sampled in the detect cycle.
//     - A level held high produces one event only.
//     - Events in IDLE, DONE and ERR are ignored.
//     - Minimum host strobe period: 2*(SYNC_STAGES+2) clk.
//   IDLE: core_rst=0.
//     - boot_req=1 -> LEN_LO.
//     - On that transition: core_rst=1, busy=1, done=0, err=0, words_wr=0, chk=0, byte_idx=0, ram_addr=0.
//   LEN_LO/LEN_HI: capture N[7:0], then N[15:8].
//     - After LEN_HI: N==0 -> CHK. N>2**ADDR_W -> ERR. Otherwise -> DATA.
//   DATA: bytes shift into ram_wdata, little-endian; byte_idx counts 0..3.
//     - On the 4th byte, ram_we=1 for exactly the next cycle, with ram_addr = current word index.
//     - After the pulse: ram_addr increments, words_wr increments.
//     - words_wr==N -> CHK.
//     - ram_addr wraps only via N==2**ADDR_W. The final increment is not used.
//   Checksum: chk ^= every byte received in LEN_LO, LEN_HI and DATA.
//   CHK: the received byte is compared with chk.
//     - Equal -> DONE: done=1, busy=0, core_rst=0 the following cycle.
//     - Unequal -> ERR: err=1, busy=0, core_rst stays 1.
//   Abort: boot_req=0 in any busy state -> ERR in the next cycle.
//     - No further ram_we.
//     - A word that is partially assembled is discarded.
//   DONE/ERR are sticky. boot_req=0 -> IDLE with done/err held. boot_req=1 in IDLE starts a new session.
//   ERR with boot_req already low: stays in ERR for 1 cycle, then -> IDLE with err held.
//     - core_rst is then 0 in IDLE; host retries by raising boot_req.
//   Simultaneous ram_we and byte event cannot occur under the strobe-period rule. If it does occur,
//     the write completes and the byte is processed in the same cycle.
//   rst mid-session: immediate return to reset values. RAM contents already written are left as-is.
// STRUCTURE
//   Package boot_loader_pkg: state enum, BYTES_PER_WORD=4, LEN_BYTES=2.
//   Sub-module sync_edge_det: SYNC_STAGES-flop synchronizer plus rising-edge pulse. Used for byte_stb.
//   The top level holds the FSM, byte_idx, word counter, word shift register and checksum register.
// TESTING
//   1 rst=1 for 3 clk, boot_req=0 -> core_rst=1, ram_we=0, done=0, err=0. After release, core_rst=0, state IDLE.
//   2 boot_req=1; bytes 02 00 EF BE AD DE 78 56 34 12 28 -> ram_we at addr0 with DEADBEEF,
//     ram_we at addr1 with 12345678, words_wr=2, done=1, core_rst=0.
//   3 Same stream with final byte 29 -> err=1, core_rst=1, done=0, two writes occurred.
//   4 ADDR_W=10; bytes 01 04 (N=1025) -> err=1 after 2nd byte, no ram_we.
//   5 Header 02 00, 3 data bytes, then boot_req=0 -> err=1, zero writes.
//     Then boot_req=1 and a clean 1-word load -> done=1, err=0.
//   6 byte_stb held high 20 clk counts as one byte. Strobes in IDLE produce no state change.
//     Header 00 00 with chk 00 -> done=1, words_wr=0.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
//
// Purpose: loader FSM state encoding, stream framing constants and a busy-state helper.
// Ports:   none (package).

package boot_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;

   // States during which a session is considered in progress.
   function automatic logic is_busy_state(input state_t s);
      return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHK);
   endfunction

endpackage

// File: rtl/imem_boot_loader_sync_edge_det.sv
// rtl/imem_boot_loader_sync_edge_det.sv - synchronizer with single-cycle rising-edge pulse
//
// Purpose: brings an asynchronous pad level into the clk domain through SYNC_STAGES flops and
//          emits one pulse per rising edge of the synchronized level.
// Ports:
//   i_clk    in   system clock
//   i_rst    in   synchronous, active-high reset
//   i_async  in   asynchronous level from the pad
//   o_rise   out  one-cycle pulse on each synchronized rising edge

module sync_edge_det
   import boot_loader_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // A level held high yields exactly one pulse because r_prev follows it.
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - fills the instruction RAM from a byte stream and gates core reset
//
// Purpose: receives a 16-bit word count, N little-endian 32-bit words and an XOR checksum,
//          one byte per strobe, writes the words into instruction RAM and holds the core in
//          reset until the image has been written and verified.
// Ports:
//   i_clk        in   system clock
//   i_rst        in   synchronous, active-high reset
//   i_boot_req   in   host load request (level)
//   i_byte_stb   in   asynchronous byte strobe, one byte per rising edge
//   i_byte_data  in   byte value accompanying the strobe
//   o_core_rst   out  reset to the core
//   o_ram_we     out  one-cycle RAM write pulse
//   o_ram_addr   out  RAM word address
//   o_ram_wdata  out  assembled 32-bit word
//   o_busy       out  session in progress
//   o_done       out  last session passed checksum
//   o_err        out  last session failed
//   o_words_wr   out  words written in current/last session

module imem_boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_boot_req,
   input  logic              i_byte_stb,
   input  logic [7:0]        i_byte_data,
   output logic              o_core_rst,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [31:0]       o_ram_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W:0]   o_words_wr
);

   localparam int LEN_W     = LEN_BYTES * 8;
   localparam int WORD_W    = BYTES_PER_WORD * 8;
   localparam int IDX_W     = $clog2(BYTES_PER_WORD);
   localparam int MAX_WORDS = 1 << ADDR_W;

   state_t              r_state;
   logic [LEN_W-1:0]    r_len;
   logic [7:0]          r_chk;
   logic [IDX_W-1:0]    r_byte_idx;
   logic [WORD_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_words;
   logic                r_we;
   logic                r_core_rst;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic                w_byte;
   logic [LEN_W-1:0]    w_len_full;
   logic [ADDR_W:0]     w_words_next;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_stb_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_byte_stb),
      .o_rise  (w_byte)
   );

   assign w_len_full   = {i_byte_data, r_len[7:0]};
   assign w_words_next = r_words + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_chk      <= '0;
         r_byte_idx <= '0;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_words    <= '0;
         r_we       <= 1'b0;
         r_core_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_core_rst <= 1'b0;
               if (i_boot_req) begin
                  r_state    <= S_LEN_LO;
                  r_core_rst <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_words    <= '0;
                  r_chk      <= '0;
                  r_byte_idx <= '0;
                  r_addr     <= '0;
               end
            end

            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
               if (!i_boot_req) begin
                  // Abort: any half-built word is dropped and no further writes issue.
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  // Finish the bookkeeping of the write pulse issued last cycle.
                  if (r_we) begin
                     r_addr  <= r_addr + 1'b1;
                     r_words <= w_words_next;
                     if (32'(w_words_next) == 32'(r_len)) begin
                        r_state <= S_CHK;
                     end
                  end
                  if (w_byte) begin
                     case (r_state)
                        S_LEN_LO: begin
                           r_len[7:0] <= i_byte_data;
                           r_chk      <= r_chk ^ i_byte_data;
                           r_state    <= S_LEN_HI;
                        end
                        S_LEN_HI: begin
                           r_len <= w_len_full;
                           r_chk <= r_chk ^ i_byte_data;
                           if (w_len_full == '0) begin
                              r_state <= S_CHK;
                           end else if (32'(w_len_full) > MAX_WORDS) begin
                              r_state <= S_ERR;
                              r_err   <= 1'b1;
                              r_busy  <= 1'b0;
                           end else begin
                              r_state <= S_DATA;
                           end
                        end
                        S_DATA: begin
                           // Little-endian: the first byte of a word ends up in bits 7:0.
                           r_wdata    <= {i_byte_data, r_wdata[WORD_W-1:8]};
                           r_chk      <= r_chk ^ i_byte_data;
                           r_byte_idx <= r_byte_idx + 1'b1;
                           if (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                              r_we <= 1'b1;
                           end
                        end
                        S_CHK: begin
                           r_busy <= 1'b0;
                           if (i_byte_data == r_chk) begin
                              r_state    <= S_DONE;
                              r_done     <= 1'b1;
                              r_core_rst <= 1'b0;
                           end else begin
                              r_state <= S_ERR;
                              r_err   <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end

            // Sticky result states; dropping the request returns to IDLE with flags held.
            S_DONE: begin
               if (!i_boot_req) begin
                  r_state <= S_IDLE;
               end
            end

            S_ERR: begin
               if (!i_boot_req) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_core_rst  = r_core_rst;
   assign o_ram_we    = r_we;
   assign o_ram_addr  = r_addr;
   assign o_ram_wdata = r_wdata;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_words_wr  = r_words;

endmodule
